// File: rtl/mem_port_arbiter.sv
// Shares one 256-bit physical-memory port between the I-cache and D-cache.
// Grants one requester at a time and keeps grant/conflict counters.
module mem_port_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_read,
    input  logic                 i_write,
    input  logic [31:0]          i_addr,
    input  logic [255:0]         i_wdata,
    output logic                 i_resp,
    output logic [255:0]         i_rdata,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [31:0]          d_addr,
    input  logic [255:0]         d_wdata,
    output logic                 d_resp,
    output logic [255:0]         d_rdata,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_address,
    output logic [255:0]         pmem_wdata,
    input  logic                 pmem_resp,
    input  logic [255:0]         pmem_rdata,
    output logic [CNT_WIDTH-1:0] perf_i_grants,
    output logic [CNT_WIDTH-1:0] perf_d_grants,
    output logic [CNT_WIDTH-1:0] perf_conflicts
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_e;

    localparam bit                   DATA_PRIO = (PRIORITY_MODE == 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};

    state_e               state_q, state_d;
    logic                 last_d_q, last_d_d;   // 1 when the most recent grant went to D
    logic [CNT_WIDTH-1:0] i_cnt_q, i_cnt_d;
    logic [CNT_WIDTH-1:0] d_cnt_q, d_cnt_d;
    logic [CNT_WIDTH-1:0] c_cnt_q, c_cnt_d;
    logic                 i_act_s, d_act_s;

    assign i_act_s = i_read | i_write;
    assign d_act_s = d_read | d_write;

    // State, last-grant and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b0;
            i_cnt_q  <= CNT_ZERO;
            d_cnt_q  <= CNT_ZERO;
            c_cnt_q  <= CNT_ZERO;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            i_cnt_q  <= i_cnt_d;
            d_cnt_q  <= d_cnt_d;
            c_cnt_q  <= c_cnt_d;
        end
    end

    // Arbitration, next state and port muxing; write wins over read on a forwarded request
    always_comb begin
        state_d      = state_q;
        last_d_d     = last_d_q;
        i_cnt_d      = i_cnt_q;
        d_cnt_d      = d_cnt_q;
        c_cnt_d      = c_cnt_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'h0000_0000;
        pmem_wdata   = {256{1'b0}};
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_act_s && d_act_s) begin
                    c_cnt_d = c_cnt_q + CNT_ONE;
                    if (DATA_PRIO || !last_d_q) begin
                        state_d  = ST_SERVE_D;
                        last_d_d = 1'b1;
                        d_cnt_d  = d_cnt_q + CNT_ONE;
                    end else begin
                        state_d  = ST_SERVE_I;
                        last_d_d = 1'b0;
                        i_cnt_d  = i_cnt_q + CNT_ONE;
                    end
                end else if (i_act_s) begin
                    state_d  = ST_SERVE_I;
                    last_d_d = 1'b0;
                    i_cnt_d  = i_cnt_q + CNT_ONE;
                end else if (d_act_s) begin
                    state_d  = ST_SERVE_D;
                    last_d_d = 1'b1;
                    d_cnt_d  = d_cnt_q + CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE_I: begin
                pmem_write   = i_write;
                pmem_read    = i_read & ~i_write;
                pmem_address = i_addr;
                pmem_wdata   = i_wdata;
                i_resp       = pmem_resp;
                if (pmem_resp || !i_act_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVE_I;
                end
            end
            ST_SERVE_D: begin
                pmem_write   = d_write;
                pmem_read    = d_read & ~d_write;
                pmem_address = d_addr;
                pmem_wdata   = d_wdata;
                d_resp       = pmem_resp;
                if (pmem_resp || !d_act_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SERVE_D;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data is broadcast; each cache qualifies it with its own resp
    assign i_rdata        = pmem_rdata;
    assign d_rdata        = pmem_rdata;
    assign perf_i_grants  = i_cnt_q;
    assign perf_d_grants  = d_cnt_q;
    assign perf_conflicts = c_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance per priority mode, both checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           i_read[2], i_write[2], d_read[2], d_write[2];
    logic [31:0]    i_addr[2], d_addr[2];
    logic [255:0]   i_wdata[2], d_wdata[2], pmem_rdata[2];
    logic           pmem_resp[2];
    logic           i_resp[2], d_resp[2], pmem_read[2], pmem_write[2];
    logic [31:0]    pmem_address[2];
    logic [255:0]   i_rdata[2], d_rdata[2], pmem_wdata[2];
    logic [CW-1:0]  perf_i[2], perf_d[2], perf_c[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.PRIORITY_MODE(g), .CNT_WIDTH(CW)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .i_read(i_read[g]), .i_write(i_write[g]), .i_addr(i_addr[g]), .i_wdata(i_wdata[g]),
            .i_resp(i_resp[g]), .i_rdata(i_rdata[g]),
            .d_read(d_read[g]), .d_write(d_write[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_resp(d_resp[g]), .d_rdata(d_rdata[g]),
            .pmem_read(pmem_read[g]), .pmem_write(pmem_write[g]),
            .pmem_address(pmem_address[g]), .pmem_wdata(pmem_wdata[g]),
            .pmem_resp(pmem_resp[g]), .pmem_rdata(pmem_rdata[g]),
            .perf_i_grants(perf_i[g]), .perf_d_grants(perf_d[g]), .perf_conflicts(perf_c[g])
        );
    end

    // model: owner 0 = nobody, 1 = I-cache, 2 = D-cache
    int          owner[2];
    bit          last_d[2];
    int          cnt_i[2], cnt_d[2], cnt_c[2];
    bit          model_ok = 1'b0;
    int          glog[2][$];
    // requester / memory stimulus state, side 0 = I, 1 = D
    bit          rq_rd[2][2], rq_wr[2][2];
    logic [31:0] rq_addr[2][2];
    logic [255:0] rq_wd[2][2];
    int          rq_left[2][2];
    int          serve_cnt[2], lat[2];
    int          fix_lat = 1;
    bit          rand_mode = 1'b0;
    bit          stray[2];
    // observations of the DUT
    logic [32:0] alog[2][$];
    bit          prev_busy[2];
    int          rd_cycles[2], iresp_cnt[2], dresp_cnt[2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, int m, logic [255:0] act, logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s mode%0d t=%0t: got %h expected %h", nm, m, $time, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [32:0] alog_at(int m, int k);
        if (k < alog[m].size()) return alog[m][k];
        return {33{1'b1}};
    endfunction

    function automatic int glog_at(int m, int k);
        if (k < glog[m].size()) return glog[m][k];
        return -1;
    endfunction

    task automatic set_req(int m, int s, bit rd, bit wr, logic [31:0] a, logic [255:0] wd, int n);
        rq_rd[m][s] = rd; rq_wr[m][s] = wr; rq_addr[m][s] = a; rq_wd[m][s] = wd; rq_left[m][s] = n;
    endtask

    task automatic drive();
        for (int m = 0; m < 2; m++) begin
            if (owner[m] == 0) serve_cnt[m] = 0;
            else serve_cnt[m]++;
            pmem_resp[m] = (owner[m] != 0 && serve_cnt[m] == lat[m]) || stray[m] ||
                           (rand_mode && owner[m] == 0 && $urandom_range(0, 7) == 0);
            pmem_rdata[m] = rand_line();
            for (int s = 0; s < 2; s++) begin
                if (rand_mode) begin
                    if (rq_left[m][s] == 0 && $urandom_range(0, 3) == 0) begin
                        int k;
                        k = $urandom_range(0, 2);
                        set_req(m, s, k != 1, k != 0, $urandom, rand_line(), 1);
                    end else if (rq_left[m][s] > 0 && $urandom_range(0, 24) == 0) begin
                        rq_left[m][s] = 0;
                    end
                end
                if (rq_left[m][s] == 0) begin
                    rq_rd[m][s] = 1'b0; rq_wr[m][s] = 1'b0;
                end
            end
            i_read[m] = rq_rd[m][0]; i_write[m] = rq_wr[m][0];
            i_addr[m] = rq_addr[m][0]; i_wdata[m] = rq_wd[m][0];
            d_read[m] = rq_rd[m][1]; d_write[m] = rq_wr[m][1];
            d_addr[m] = rq_addr[m][1]; d_wdata[m] = rq_wd[m][1];
        end
    endtask

    task automatic compare(int m);
        logic e_pr, e_pw, e_ir, e_dr;
        logic [31:0] e_ad;
        logic [255:0] e_wd;
        bit busy;
        e_pr = 1'b0; e_pw = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_ad = 32'h0; e_wd = {256{1'b0}};
        if (owner[m] == 1) begin
            e_pw = i_write[m]; e_pr = i_read[m] & ~i_write[m];
            e_ad = i_addr[m];  e_wd = i_wdata[m]; e_ir = pmem_resp[m];
        end else if (owner[m] == 2) begin
            e_pw = d_write[m]; e_pr = d_read[m] & ~d_write[m];
            e_ad = d_addr[m];  e_wd = d_wdata[m]; e_dr = pmem_resp[m];
        end
        chk("pmem_read", m, pmem_read[m], e_pr);
        chk("pmem_write", m, pmem_write[m], e_pw);
        chk("pmem_address", m, pmem_address[m], e_ad);
        chk("pmem_wdata", m, pmem_wdata[m], e_wd);
        chk("i_resp", m, i_resp[m], e_ir);
        chk("d_resp", m, d_resp[m], e_dr);
        if (e_ir) chk("i_rdata", m, i_rdata[m], pmem_rdata[m]);
        if (e_dr) chk("d_rdata", m, d_rdata[m], pmem_rdata[m]);
        chk("perf_i_grants", m, perf_i[m], cnt_i[m] % (1 << CW));
        chk("perf_d_grants", m, perf_d[m], cnt_d[m] % (1 << CW));
        chk("perf_conflicts", m, perf_c[m], cnt_c[m] % (1 << CW));
        busy = pmem_read[m] | pmem_write[m];
        if (busy && !prev_busy[m]) alog[m].push_back({pmem_write[m], pmem_address[m]});
        prev_busy[m] = busy;
        if (pmem_read[m]) rd_cycles[m]++;
        if (i_resp[m]) iresp_cnt[m]++;
        if (d_resp[m]) dresp_cnt[m]++;
        if (e_ir && rq_left[m][0] > 0) rq_left[m][0]--;
        if (e_dr && rq_left[m][1] > 0) rq_left[m][1]--;
    endtask

    task automatic advance(int m);
        bit ia, da;
        int win;
        ia = i_read[m] | i_write[m];
        da = d_read[m] | d_write[m];
        if (!rst_n) begin
            owner[m] = 0; last_d[m] = 1'b0; cnt_i[m] = 0; cnt_d[m] = 0; cnt_c[m] = 0;
        end else if (owner[m] == 0) begin
            win = 0;
            if (ia && da) begin
                cnt_c[m]++;
                win = (m == 1 || !last_d[m]) ? 2 : 1;
            end else if (ia) win = 1;
            else if (da) win = 2;
            if (win != 0) begin
                owner[m] = win;
                last_d[m] = (win == 2);
                if (win == 1) cnt_i[m]++;
                else cnt_d[m]++;
                glog[m].push_back(win);
                lat[m] = rand_mode ? int'($urandom_range(1, 4)) : fix_lat;
            end
        end else if (pmem_resp[m] || !(owner[m] == 1 ? ia : da)) begin
            owner[m] = 0;
        end
    endtask

    task automatic cyc();
        drive();
        #1;
        if (model_ok) for (int m = 0; m < 2; m++) compare(m);
        @(posedge clk);
        for (int m = 0; m < 2; m++) advance(m);
        if (!rst_n) model_ok = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_obs();
        for (int m = 0; m < 2; m++) begin
            alog[m].delete(); glog[m].delete();
            prev_busy[m] = 1'b0; rd_cycles[m] = 0; iresp_cnt[m] = 0; dresp_cnt[m] = 0;
        end
    endtask

    task automatic do_reset();
        for (int m = 0; m < 2; m++) begin
            stray[m] = 1'b0;
            for (int s = 0; s < 2; s++) rq_left[m][s] = 0;
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        clear_obs();
    endtask

    initial begin
        logic [255:0] a5_line;
        a5_line = {32{8'hA5}};
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            owner[m] = 0; last_d[m] = 1'b0; cnt_i[m] = 0; cnt_d[m] = 0; cnt_c[m] = 0;
            serve_cnt[m] = 0; lat[m] = 1; stray[m] = 1'b0;
            for (int s = 0; s < 2; s++) set_req(m, s, 1'b0, 1'b0, 32'h0, {256{1'b0}}, 0);
        end
        @(negedge clk);

        // single I-cache read, memory answers in the third serve cycle
        do_reset();
        fix_lat = 3;
        for (int m = 0; m < 2; m++) set_req(m, 0, 1'b1, 1'b0, 32'h0000_0040, {256{1'b0}}, 1);
        repeat (8) cyc();
        for (int m = 0; m < 2; m++) begin
            chk("t1_read_cycles", m, rd_cycles[m], 3);
            chk("t1_i_resp_pulses", m, iresp_cnt[m], 1);
            chk("t1_d_resp_pulses", m, dresp_cnt[m], 0);
            chk("t1_perf_i", m, perf_i[m], 1);
            chk("t1_first_req", m, alog_at(m, 0), {1'b0, 32'h0000_0040});
        end

        // sustained conflict, four 2-cycle transactions
        do_reset();
        fix_lat = 2;
        for (int m = 0; m < 2; m++) begin
            set_req(m, 0, 1'b1, 1'b0, 32'h0000_0100, {256{1'b0}}, 100);
            set_req(m, 1, 1'b1, 1'b0, 32'h0000_0200, {256{1'b0}}, 100);
        end
        repeat (12) cyc();
        chk("t2_m0_conflicts", 0, perf_c[0], 4);
        chk("t2_m0_d_grants", 0, perf_d[0], 2);
        chk("t2_m0_i_grants", 0, perf_i[0], 2);
        chk("t2_m1_conflicts", 1, perf_c[1], 4);
        chk("t2_m1_d_grants", 1, perf_d[1], 4);
        chk("t2_m1_i_grants", 1, perf_i[1], 0);
        for (int k = 0; k < 4; k++) begin
            chk("t2_m0_order", 0, alog_at(0, k), {1'b0, (k % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100});
            chk("t2_m1_order", 1, alog_at(1, k), {1'b0, 32'h0000_0200});
            chk("t2_m0_model_order", 0, glog_at(0, k), (k % 2 == 0) ? 2 : 1);
            chk("t2_m1_model_order", 1, glog_at(1, k), 2);
        end
        for (int m = 0; m < 2; m++) rq_left[m][1] = 0;
        repeat (4) cyc();
        for (int m = 0; m < 2; m++) chk("t2_i_after_d_drops", m, alog_at(m, 4), {1'b0, 32'h0000_0100});

        // D write and I read raised together
        do_reset();
        fix_lat = 2;
        for (int m = 0; m < 2; m++) begin
            set_req(m, 1, 1'b0, 1'b1, 32'h1000_0000, a5_line, 1);
            set_req(m, 0, 1'b1, 1'b0, 32'h0000_0020, {256{1'b0}}, 1);
        end
        repeat (8) cyc();
        for (int m = 0; m < 2; m++) begin
            chk("t3_first_write", m, alog_at(m, 0), {1'b1, 32'h1000_0000});
            chk("t3_then_read", m, alog_at(m, 1), {1'b0, 32'h0000_0020});
            chk("t3_i_resp_pulses", m, iresp_cnt[m], 1);
            chk("t3_d_resp_pulses", m, dresp_cnt[m], 1);
        end

        // reset in the middle of a D transfer, late pmem_resp afterwards
        do_reset();
        fix_lat = 5;
        for (int m = 0; m < 2; m++) set_req(m, 1, 1'b1, 1'b0, 32'h0000_0300, {256{1'b0}}, 1);
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        clear_obs();
        for (int m = 0; m < 2; m++) begin
            chk("t4_perf_i_zero", m, perf_i[m], 0);
            chk("t4_perf_d_zero", m, perf_d[m], 0);
            chk("t4_perf_c_zero", m, perf_c[m], 0);
            stray[m] = 1'b1;
            set_req(m, 0, 1'b1, 1'b0, 32'h0000_0400, {256{1'b0}}, 1);
        end
        fix_lat = 2;
        cyc();
        for (int m = 0; m < 2; m++) stray[m] = 1'b0;
        cyc();
        for (int m = 0; m < 2; m++) begin
            chk("t4_late_resp_dropped", m, dresp_cnt[m] + iresp_cnt[m], 0);
            chk("t4_conflict_to_d", m, alog_at(m, 0), {1'b0, 32'h0000_0300});
            chk("t4_model_conflict_to_d", m, glog_at(m, 0), 2);
        end
        repeat (8) cyc();

        // counter wrap with CNT_WIDTH = 4
        do_reset();
        fix_lat = 1;
        for (int m = 0; m < 2; m++) set_req(m, 0, 1'b1, 1'b0, 32'h0000_0500, {256{1'b0}}, 17);
        repeat (40) cyc();
        for (int m = 0; m < 2; m++) begin
            chk("t5_all_done", m, rq_left[m][0], 0);
            chk("t5_perf_i_wrapped", m, perf_i[m], 1);
            chk("t5_model_grants", m, glog[m].size(), 17);
        end

        // D withdraws before any response arrives
        do_reset();
        fix_lat = 6;
        for (int m = 0; m < 2; m++) set_req(m, 1, 1'b1, 1'b0, 32'h0000_0600, {256{1'b0}}, 1);
        repeat (3) cyc();
        for (int m = 0; m < 2; m++) rq_left[m][1] = 0;
        repeat (6) cyc();
        for (int m = 0; m < 2; m++) begin
            chk("t6_abort_read_cycles", m, rd_cycles[m], 2);
            chk("t6_abort_no_resp", m, dresp_cnt[m], 0);
        end

        // randomized traffic with occasional resets
        rand_mode = 1'b1;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cyc();
        end
        rst_n = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single 256-bit physical-memory port between the instruction cache (i_*) and the data cache (d_*) inside the cache group. It grants one cache at a time, forwards that cache's line read/write to pmem, routes pmem_resp back to the granted cache, and keeps grant/conflict performance counters. Arbitration is round-robin or fixed data-priority, selected by parameter.

## Interface
- PRIORITY_MODE, 0, 0 = round-robin on conflict; 1 = data cache always wins conflicts
- CNT_WIDTH, 32, width of each performance counter
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- i_read / i_write  in  1 each  I-cache line read / write request, held until i_resp
- i_addr  in  32  I-cache line address
- i_wdata  in  256  I-cache write line
- i_resp  out  1  I-cache completion
- i_rdata  out  256  read line to I-cache
- d_read / d_write / d_addr / d_wdata / d_resp / d_rdata: same as i_* for the data cache
- pmem_read / pmem_write  out  1 each  memory request
- pmem_address  out  32
- pmem_wdata  out  256
- pmem_resp  in  1  memory completion (one-cycle pulse)
- pmem_rdata  in  256  memory read line
- perf_i_grants / perf_d_grants  out  CNT_WIDTH  grants issued per requester
- perf_conflicts  out  CNT_WIDTH  IDLE cycles in which both requesters were active

## Operation
- A requester is active when read|write is high. Write wins if both are driven high: forwarded as pmem_write only.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE: pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0. Only I active -> SERVE_I. Only D active -> SERVE_D. Both active -> mode 1: SERVE_D; mode 0: grant the requester not in last_grant. Neither active -> stay.
- last_grant (1 bit) updates on each grant; reset value I, so the first conflict after reset goes to D in either mode.
- SERVE_X: pmem_read/write/address/wdata mirror X's inputs combinationally. x_resp = pmem_resp; the other requester's resp = 0. pmem_resp -> IDLE next edge.
- Abort: in SERVE_X with X inactive and pmem_resp=0 -> IDLE next edge, no resp issued.
- pmem_resp in IDLE is ignored: neither i_resp nor d_resp asserts.
- i_rdata = d_rdata = pmem_rdata, broadcast and valid only when the matching resp is high.
- Counters increment on the IDLE->SERVE edge (grant counter of the winner; perf_conflicts if both were active). They wrap modulo 2^CNT_WIDTH with no saturation.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, last_grant=I, all counters 0. All pmem_* outputs and i_resp/d_resp are 0 from the next cycle. Reset mid-SERVE abandons the transfer; a late pmem_resp is dropped.
- Grant latency: a request first seen active in IDLE at cycle N is forwarded to pmem in cycle N+1.
- Response is combinational: x_resp is high in the same cycle as pmem_resp. State is IDLE in the following cycle.
- At least one IDLE cycle separates consecutive grants, so a transaction of L pmem cycles occupies L+1 cycles back-to-back.
- Requests arriving during SERVE are held by the requester and evaluated in the next IDLE. Under sustained conflict in mode 0, grants strictly alternate.
- Outputs to the non-granted cache never change because of the other cache's traffic.

## Test plan
- Reset then single I read at 0x0000_0040, pmem_resp after 3 cycles -> pmem_read high cycles N+1..N+3 with address 0x40; i_resp pulses with pmem_resp; i_rdata = pmem_rdata; d_resp stays 0; perf_i_grants = 1.
- Mode 0: I and D both active from reset, each completing after 2 cycles, held for 4 transactions -> grant order D,I,D,I; perf_conflicts = 4; perf_d_grants = perf_i_grants = 2.
- Mode 1: same stimulus -> D granted every time while D stays active; I is granted only after D deasserts.
- D write to 0x1000_0000 with wdata = 0xA5 repeated, while I reads 0x20 in the same cycle -> pmem_write with D's address and data first, then pmem_read 0x20; each resp is routed only to its owner.
- Reset asserted mid-SERVE_D, then pmem_resp pulses in the next cycle -> no d_resp; pmem_* = 0; counters = 0; the next conflict is granted to D.
- CNT_WIDTH=4: 17 I grants -> perf_i_grants wraps to 1. Abort case: D drops its request before pmem_resp -> IDLE next cycle, d_resp never asserts.
